// File: rtl/trng_pkg.sv
// Shared types and constants for the ring-oscillator TRNG harvester.
// State encoding, default parameters and a counter-width helper.
package trng_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam int DEF_N         = 10;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DIV       = 16;
  localparam int DEF_WARMUP    = 64;
  localparam int DEF_REP_LIMIT = 32;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/trng_harvester_if.sv
// Word delivery channel of the TRNG harvester.
// Valid/ready handshake carrying one harvested word.
interface trng_harvester_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] RAND_DATA;
  logic             RAND_VALID;
  logic             RAND_READY;

  modport master (
    output RAND_DATA,
    output RAND_VALID,
    input  RAND_READY
  );

  modport slave (
    input  RAND_DATA,
    input  RAND_VALID,
    output RAND_READY
  );

endinterface

// File: rtl/trng_health_rep.sv
// Repetition-count health test on the raw TRNG bit stream.
// Trips when REP_LIMIT identical bits arrive on consecutive ticks.
module trng_health_rep
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_bit,
  input  logic tick,
  input  logic clear,
  output logic trip
);

  localparam int CW = clog2(REP_LIMIT + 1);

  logic [CW-1:0] rep_cnt;
  logic [CW-1:0] rep_nxt;
  logic          prev_bit;
  logic          first;

  always_comb begin
    rep_nxt = rep_cnt;
    if (first || (raw_bit != prev_bit)) begin
      rep_nxt = CW'(1);
    end else if (rep_cnt != CW'(REP_LIMIT)) begin
      rep_nxt = rep_cnt + 1'b1;
    end
  end

  assign trip = tick && !clear &&
                (rep_nxt == CW'(REP_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt  <= '0;
      prev_bit <= 1'b0;
      first    <= 1'b1;
    end else if (clear) begin
      rep_cnt  <= '0;
      prev_bit <= 1'b0;
      first    <= 1'b1;
    end else if (tick) begin
      rep_cnt  <= rep_nxt;
      prev_bit <= raw_bit;
      first    <= 1'b0;
    end
  end

endmodule

// File: rtl/trng_harvester.sv
// Ring-oscillator TRNG harvester: sync, sample, health test, pack.
// Optional von Neumann debias when TRNG_VN_DEBIAS_EN is defined.
module trng_harvester
  import trng_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter int WARMUP    = DEF_WARMUP,
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic [N-1:0]     RO_IN,
  input  logic             FAULT_CLR,
  output logic             FAULT,
  output logic             BUSY,
  trng_harvester_if.master rnd
);

  localparam int DW = clog2(DIV);
  localparam int WW = clog2(WARMUP);
  localparam int BW = clog2(WIDTH);

  state_t state_q;
  state_t state_d;

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic             raw_bit;
  logic [DW-1:0]    div_cnt;
  logic [WW-1:0]    warm_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             fault_q;
  logic             active;
  logic             tick;
  logic             coll_tick;
  logic             bit_ok;
  logic             bit_val;
  logic             last_bit;
  logic             trip;

  assign raw_bit = ^sync2;

  assign active = (state_q != S_IDLE) &&
                  (state_q != S_FAULT);
  assign tick   = active &&
                  (div_cnt == DW'(DIV - 1));

  assign coll_tick = tick &&
                     (state_q == S_COLLECT);

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_full;
  logic pair_bit;

  // First bit of a pair is the output when the pair differs.
  assign bit_ok  = coll_tick && pair_full &&
                   (pair_bit != raw_bit);
  assign bit_val = pair_bit;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pair_full <= 1'b0;
      pair_bit  <= 1'b0;
    end else if (state_q != S_COLLECT) begin
      pair_full <= 1'b0;
      pair_bit  <= 1'b0;
    end else if (tick) begin
      pair_full <= ~pair_full;
      pair_bit  <= raw_bit;
    end
  end
`else
  assign bit_ok  = coll_tick;
  assign bit_val = raw_bit;
`endif

  assign last_bit = bit_ok &&
                    (bit_cnt == BW'(WIDTH - 1));

  always_comb begin
    word          = acc;
    word[bit_cnt] = bit_val;
  end

  trng_health_rep #(
    .REP_LIMIT (REP_LIMIT)
  ) u_health (
    .clk     (CLK),
    .rst_n   (RST_n),
    .raw_bit (raw_bit),
    .tick    (tick),
    .clear   (!active),
    .trip    (trip)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (EN) state_d = S_WARMUP;
      end
      S_WARMUP: begin
        if (!EN) begin
          state_d = S_IDLE;
        end else if (tick &&
            (warm_cnt == WW'(WARMUP - 1))) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (!EN)           state_d = S_IDLE;
        else if (last_bit) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!EN)                 state_d = S_IDLE;
        else if (rnd.RAND_READY) state_d = S_COLLECT;
      end
      S_FAULT: begin
        if (FAULT_CLR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A trip overrides EN loss and any completed transfer.
    if (trip) state_d = S_FAULT;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      sync1    <= '0;
      sync2    <= '0;
      div_cnt  <= '0;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      acc      <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1   <= RO_IN;
      sync2   <= sync1;

      if (!active || tick) div_cnt <= '0;
      else                 div_cnt <= div_cnt + 1'b1;

      if (state_q != S_WARMUP) warm_cnt <= '0;
      else if (tick)           warm_cnt <= warm_cnt + 1'b1;

      if (state_q != S_COLLECT) bit_cnt <= '0;
      else if (last_bit)        bit_cnt <= '0;
      else if (bit_ok)          bit_cnt <= bit_cnt + 1'b1;

      if (bit_ok) acc <= word;

      if ((state_q == S_COLLECT) &&
          (state_d == S_HOLD)) begin
        data_q <= word;
      end

      valid_q <= (state_d == S_HOLD);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign rnd.RAND_DATA  = data_q;
  assign rnd.RAND_VALID = valid_q;
  assign FAULT          = fault_q;
  assign BUSY           = (state_q == S_WARMUP) ||
                          (state_q == S_COLLECT);

endmodule
